id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL expose: clk  in  1  single rising-edge clock for all state.
REQ-002 SHALL expose: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL expose: in_valid  in  1  decoded-instruction fields below are valid this cycle.
REQ-004 SHALL expose: in_ready  out  1  stage accepts a new instruction this cycle.
REQ-005 SHALL expose: opcode  in  6, funct  in  6, imm  in  16  instruction fields.
REQ-006 SHALL expose: rs_num, rt_num, rd_num  in  5 each  register numbers.
REQ-007 SHALL expose: rs_data, rt_data  in  32 each  register-file read values.
REQ-008 SHALL expose: fwd_en  in  1, fwd_reg  in  5, fwd_data  in  32  forwarding source from the ALU's registered result.
REQ-009 SHALL expose: stall  in  1 and flush  in  1  pipeline control.
REQ-010 SHALL expose: a, b  out  32 each; operation  out  3  ALU operands and op code.
REQ-011 SHALL expose: out_valid  out  1; dest_reg  out  5; illegal  out  1; illegal_count  out  8.

Function
REQ-012 SHALL use ALU op codes: AND 000, OR 001, ADD 010, SUB 110, SLT 111.
REQ-013 SHALL decode opcode 000000 by funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT; b = rt operand; dest = rd_num.
REQ-014 SHALL decode: 001000 addi ADD, 001010 slti SLT (b = sign-extended imm); 001100 andi AND, 001101 ori OR (b = zero-extended imm); dest = rt_num.
REQ-015 SHALL decode 000100 beq as SUB, b = rt operand, dest = 0.
REQ-016 SHALL treat any other opcode/funct as illegal.
REQ-017 SHALL select a = fwd_data when fwd_en, fwd_reg != 0 and fwd_reg == rs_num, else rs_data; rt operand likewise against rt_num.
REQ-018 SHALL drive in_ready = ~stall combinationally.
REQ-019 SHALL capture a, b, operation, dest_reg on the edge where in_valid & in_ready & ~flush & legal, setting out_valid = 1 (latency one cycle).
REQ-020 SHALL set out_valid = 0 on any edge with in_ready = 1 and no legal capture (bubble).
REQ-021 SHALL, while stall = 1 and flush = 0, hold all outputs unchanged.
REQ-022 SHALL give flush priority over stall and in_valid: next edge out_valid = 0, dest_reg = 0, other data outputs held.
REQ-023 SHALL pulse illegal = 1 for exactly one cycle after an accepted illegal instruction (in_valid & in_ready & ~flush), out_valid = 0 that cycle.
REQ-024 SHALL increment illegal_count on each such event, saturating at 255.

Reset
REQ-025 SHALL on rst = 1, immediately and independent of clk, force a = 0, b = 0, operation = 000, dest_reg = 0, out_valid = 0, illegal = 0, illegal_count = 0.
REQ-026 SHALL discard any instruction presented during reset; first capture occurs on the first edge after rst deasserts.

Structure
REQ-027 SHALL place opcode/funct constants and ALU op-code constants in a shared package used also by the ALU control path.
REQ-028 SHALL isolate combinational decode (op, immediate-extension select, dest select, legal) in sub-module alu_decoder; forwarding muxes and registers stay in id_ex_stage.

Verification
REQ-029 SHALL cover: R-type add, rs_data=5, rt_data=7, no fwd -> next cycle a=5, b=7, operation=010, dest_reg=rd_num, out_valid=1.
REQ-030 SHALL cover: addi imm=16'hFFFF, rs_data=3 -> b=32'hFFFFFFFF, op 010; ori imm=16'hFFFF -> b=32'h0000FFFF, op 001.
REQ-031 SHALL cover: fwd_en=1, fwd_reg=rs_num=4, fwd_data=32'hDEAD -> a=32'hDEAD; same with fwd_reg=0 -> a=rs_data.
REQ-032 SHALL cover: stall=1 for 3 cycles with new in_valid -> outputs frozen, in_ready=0; flush raised during stall -> out_valid=0 next edge.
REQ-033 SHALL cover: 256 illegal opcodes (e.g. 111111) -> illegal pulses each, out_valid=0, illegal_count stops at 255.
REQ-034 SHALL cover: rst asserted mid-stream between edges -> all outputs zero immediately, before the next clk edge.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg
// Shared decode constants for the ID/EX stage and the ALU control path:
// opcode/funct encodings, ALU op codes, decoder select enums, the decode
// result struct and the operand forwarding helper.
package id_ex_stage_pkg;

  // ALU op codes seen by the execute stage
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  // opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // source of operand b: rt operand, sign- or zero-extended immediate
  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_SEXT = 2'd1,
    IMM_ZEXT = 2'd2
  } imm_sel_e;

  // source of the destination register number
  typedef enum logic [1:0] {
    DST_RD   = 2'd0,
    DST_RT   = 2'd1,
    DST_ZERO = 2'd2
  } dst_sel_e;

  typedef struct packed {
    alu_op_e  op;
    imm_sel_e imm_sel;
    dst_sel_e dst_sel;
    logic     legal;
  } dec_t;

  // Bypass from the ALU's registered result. Register 0 is hardwired zero,
  // so it is never a forwarding match.
  function automatic logic [31:0] fwd_mux(input logic        en,
                                          input logic [4:0]  fwd_reg,
                                          input logic [31:0] fwd_data,
                                          input logic [4:0]  src_reg,
                                          input logic [31:0] rf_data);
    if (en && (fwd_reg != 5'd0) && (fwd_reg == src_reg)) return fwd_data;
    return rf_data;
  endfunction

endpackage

// File: rtl/id_ex_stage_alu_decoder.sv
// alu_decoder
// Purely combinational instruction decode for the ID/EX stage.
// Ports:
//   opcode, funct : instruction fields
//   dec           : ALU op, operand-b select, destination select, legal flag
module alu_decoder
  import id_ex_stage_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec = '{op: ALU_AND, imm_sel: IMM_NONE, dst_sel: DST_ZERO, legal: 1'b0};
    unique case (opcode)
      OP_RTYPE: begin
        dec.imm_sel = IMM_NONE;
        dec.dst_sel = DST_RD;
        dec.legal   = 1'b1;
        unique case (funct)
          FN_ADD:  dec.op = ALU_ADD;
          FN_SUB:  dec.op = ALU_SUB;
          FN_AND:  dec.op = ALU_AND;
          FN_OR:   dec.op = ALU_OR;
          FN_SLT:  dec.op = ALU_SLT;
          default: dec.legal = 1'b0;
        endcase
      end
      OP_ADDI: dec = '{op: ALU_ADD, imm_sel: IMM_SEXT, dst_sel: DST_RT,   legal: 1'b1};
      OP_SLTI: dec = '{op: ALU_SLT, imm_sel: IMM_SEXT, dst_sel: DST_RT,   legal: 1'b1};
      OP_ANDI: dec = '{op: ALU_AND, imm_sel: IMM_ZEXT, dst_sel: DST_RT,   legal: 1'b1};
      OP_ORI:  dec = '{op: ALU_OR,  imm_sel: IMM_ZEXT, dst_sel: DST_RT,   legal: 1'b1};
      OP_BEQ:  dec = '{op: ALU_SUB, imm_sel: IMM_NONE, dst_sel: DST_ZERO, legal: 1'b1};
      default: ;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register: forwards operands, decodes the instruction and
// registers ALU operands/op code for execute. Counts illegal instructions.
// Ports:
//   clk, rst                    : clock, async active-high reset
//   in_valid / in_ready         : instruction handshake (in_ready = ~stall)
//   opcode, funct, imm          : instruction fields
//   rs_num, rt_num, rd_num      : register numbers
//   rs_data, rt_data            : register-file read values
//   fwd_en, fwd_reg, fwd_data   : ALU result bypass
//   stall, flush                : pipeline control (flush wins)
//   a, b, operation, dest_reg   : registered ALU inputs
//   out_valid, illegal          : registered status; illegal is a 1-cycle pulse
//   illegal_count               : saturating count of accepted illegal instrs
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [4:0]  rs_num,
  input  logic [4:0]  rt_num,
  input  logic [4:0]  rd_num,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        fwd_en,
  input  logic [4:0]  fwd_reg,
  input  logic [31:0] fwd_data,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [2:0]  operation,
  output logic        out_valid,
  output logic [4:0]  dest_reg,
  output logic        illegal,
  output logic [7:0]  illegal_count
);

  dec_t        dec;
  logic [31:0] rs_op, rt_op, b_nxt;
  logic [4:0]  dest_nxt;
  logic        accept;

  alu_decoder u_dec (
    .opcode (opcode),
    .funct  (funct),
    .dec    (dec)
  );

  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready & ~flush;

  assign rs_op = fwd_mux(fwd_en, fwd_reg, fwd_data, rs_num, rs_data);
  assign rt_op = fwd_mux(fwd_en, fwd_reg, fwd_data, rt_num, rt_data);

  always_comb begin
    b_nxt = rt_op;
    unique case (dec.imm_sel)
      IMM_SEXT: b_nxt = {{16{imm[15]}}, imm};
      IMM_ZEXT: b_nxt = {16'h0000, imm};
      default:  b_nxt = rt_op;
    endcase
  end

  always_comb begin
    dest_nxt = 5'd0;
    unique case (dec.dst_sel)
      DST_RD:  dest_nxt = rd_num;
      DST_RT:  dest_nxt = rt_num;
      default: dest_nxt = 5'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a             <= '0;
      b             <= '0;
      operation     <= ALU_AND;
      dest_reg      <= '0;
      out_valid     <= 1'b0;
      illegal       <= 1'b0;
      illegal_count <= '0;
    end else if (flush) begin
      // kill the slot; operand registers keep their last contents
      out_valid <= 1'b0;
      dest_reg  <= '0;
      illegal   <= 1'b0;
    end else if (stall) begin
      // slot frozen; illegal is a single-cycle event flag, not slot state
      illegal <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      if (accept) begin
        if (dec.legal) begin
          a         <= rs_op;
          b         <= b_nxt;
          operation <= dec.op;
          dest_reg  <= dest_nxt;
          out_valid <= 1'b1;
        end else begin
          illegal <= 1'b1;
          if (illegal_count != 8'hFF) illegal_count <= illegal_count + 8'd1;
        end
      end
    end
  end

endmodule
